avmm_rdwr_to_shared_arb: RTL and testbench

AVMM_RDWR_TO_SHARED_ARB -- requirements
Module: avmm_rdwr_to_shared_arb

---
 rtl/avmm_rdwr_to_shared_arb.sv | 146 ++++++++++++++
 tb/tb_avmm_rdwr_to_shared_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_rdwr_to_shared_arb.sv
// Merges a split read channel and write channel onto one shared Avalon-MM master.
// Reads and writes alternate under contention. Write bursts are never interleaved.
// The read issue path is throttled by the count of outstanding read beats.
module avmm_rdwr_to_shared_arb #(
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int MAX_RD_PENDING  = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // read command / response channel
  input  logic [ADDR_WIDTH-1:0]      rd_address,
  input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
  input  logic                       rd_read,
  output logic                       rd_waitrequest,
  output logic [DATA_WIDTH-1:0]      rd_readdata,
  output logic                       rd_readdatavalid,
  // write channel
  input  logic [ADDR_WIDTH-1:0]      wr_address,
  input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
  input  logic                       wr_write,
  input  logic [DATA_WIDTH-1:0]      wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
  output logic                       wr_waitrequest,
  // shared master toward the sink
  output logic [ADDR_WIDTH-1:0]      avm_address,
  output logic [BURST_CNT_WIDTH-1:0] avm_burstcount,
  output logic                       avm_read,
  output logic                       avm_write,
  output logic [DATA_WIDTH-1:0]      avm_writedata,
  output logic [DATA_WIDTH/8-1:0]    avm_byteenable,
  input  logic                       avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]      avm_readdata,
  input  logic                       avm_readdatavalid
);

  localparam int PEND_W = $clog2(MAX_RD_PENDING + 1);
  localparam int SUM_W  = PEND_W + BURST_CNT_WIDTH + 1;

  typedef enum logic {S_IDLE = 1'b0, S_WR_BURST = 1'b1} state_t;
  typedef enum logic {LG_RD = 1'b0, LG_WR = 1'b1} grant_t;

  state_t                     state_q, state_d;
  grant_t                     last_grant_q, last_grant_d;
  logic [BURST_CNT_WIDTH-1:0] wr_beats_left_q, wr_beats_left_d;
  logic [PEND_W-1:0]          rd_pending_q, rd_pending_d;

  logic [SUM_W-1:0] rd_need;
  logic [SUM_W-1:0] pend_sum;
  logic             rd_ok;
  logic             gnt_rd;
  logic             gnt_wr;
  logic             rd_acc;
  logic             wr_acc;

  // A read is admitted only if all of its beats fit in the pending budget.
  assign rd_need = SUM_W'(rd_pending_q) + SUM_W'(rd_burstcount);
  assign rd_ok   = (rd_need <= SUM_W'(MAX_RD_PENDING));

  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    if (reset_n) begin
      if (state_q == S_WR_BURST) begin
        gnt_wr = wr_write;
      end else if (rd_read && rd_ok && (!wr_write || (last_grant_q == LG_WR))) begin
        gnt_rd = 1'b1;
      end else begin
        gnt_wr = wr_write;
      end
    end
  end

  assign rd_acc = gnt_rd & ~avm_waitrequest;
  assign wr_acc = gnt_wr & ~avm_waitrequest;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      last_grant_q    <= LG_WR;
      wr_beats_left_q <= '0;
      rd_pending_q    <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      wr_beats_left_q <= wr_beats_left_d;
      rd_pending_q    <= rd_pending_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    wr_beats_left_d = wr_beats_left_q;
    case (state_q)
      S_IDLE: begin
        if (rd_acc) begin
          last_grant_d = LG_RD;
        end else if (wr_acc) begin
          last_grant_d = LG_WR;
          if (wr_burstcount > BURST_CNT_WIDTH'(1)) begin
            wr_beats_left_d = wr_burstcount - BURST_CNT_WIDTH'(1);
            state_d         = S_WR_BURST;
          end
        end
      end
      S_WR_BURST: begin
        if (wr_acc) begin
          wr_beats_left_d = wr_beats_left_q - BURST_CNT_WIDTH'(1);
          if (wr_beats_left_q == BURST_CNT_WIDTH'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Add the accepted burst before removing a returned beat. This lets a
  // same-cycle return offset a fresh accept even when the count starts at zero.
  always_comb begin
    pend_sum = SUM_W'(rd_pending_q);
    if (rd_acc) begin
      pend_sum = pend_sum + SUM_W'(rd_burstcount);
    end
    if (avm_readdatavalid && (pend_sum != '0)) begin
      pend_sum = pend_sum - SUM_W'(1);
    end
    rd_pending_d = PEND_W'(pend_sum);
  end

  always_comb begin
    avm_read         = gnt_rd;
    avm_write        = gnt_wr;
    avm_address      = gnt_wr ? wr_address : rd_address;
    avm_burstcount   = gnt_wr ? wr_burstcount : rd_burstcount;
    avm_writedata    = wr_writedata;
    avm_byteenable   = wr_byteenable;
    rd_waitrequest   = ~gnt_rd | avm_waitrequest;
    wr_waitrequest   = ~gnt_wr | avm_waitrequest;
    rd_readdata      = avm_readdata;
    rd_readdatavalid = avm_readdatavalid;
  end

endmodule

// File: tb/tb_avmm_rdwr_to_shared_arb.sv
// Scoreboard bench for avmm_rdwr_to_shared_arb.
// Directed stimulus pushes the expected beat order. A negedge monitor pops and compares it.
module tb_avmm_rdwr_to_shared_arb;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [AW-1:0] rd_address, wr_address, avm_address;
  logic [BW-1:0] rd_burstcount, wr_burstcount, avm_burstcount;
  logic          rd_read, rd_waitrequest, rd_readdatavalid;
  logic [DW-1:0] rd_readdata, wr_writedata, avm_writedata, avm_readdata;
  logic          wr_write, wr_waitrequest;
  logic [DW/8-1:0] wr_byteenable, avm_byteenable;
  logic          avm_read, avm_write, avm_waitrequest, avm_readdatavalid;

  avmm_rdwr_to_shared_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .MAX_RD_PENDING(MP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_address(rd_address), .rd_burstcount(rd_burstcount), .rd_read(rd_read),
    .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
    .rd_readdatavalid(rd_readdatavalid),
    .wr_address(wr_address), .wr_burstcount(wr_burstcount), .wr_write(wr_write),
    .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
    .wr_waitrequest(wr_waitrequest),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_cmd[$];
  logic [DW-1:0] exp_rd[$];
  beat_t         mon_e;
  logic [DW-1:0] mon_d;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_r(input logic [AW-1:0] a, input logic [BW-1:0] bc);
    exp_cmd.push_back('{wr: 1'b0, addr: a, bc: bc, data: '0});
  endtask

  task automatic exp_w(input logic [AW-1:0] a, input logic [BW-1:0] bc, input logic [DW-1:0] d);
    exp_cmd.push_back('{wr: 1'b1, addr: a, bc: bc, data: d});
  endtask

  task automatic drive(input logic rd, input logic [BW-1:0] rbc, input logic [AW-1:0] ra,
                       input logic wr, input logic [BW-1:0] wbc, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic wt, input logic rv,
                       input logic [DW-1:0] rdat);
    rd_read = rd; rd_burstcount = rbc; rd_address = ra;
    wr_write = wr; wr_burstcount = wbc; wr_address = wa; wr_writedata = wd;
    wr_byteenable = wd[DW/8-1:0];
    avm_waitrequest = wt; avm_readdatavalid = rv; avm_readdata = rdat;
    if (rv) exp_rd.push_back(rdat);
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, base + DW'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("drain_pending_zero", dut.rd_pending_q, 0);
  endtask

  // Monitor: every accepted command beat and every read return is scored.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("rd_wr_exclusive", avm_read & avm_write, 0);
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        if (exp_cmd.size() == 0) begin
          check("unexpected_beat", {avm_read, avm_write}, 0);
        end else begin
          mon_e = exp_cmd.pop_front();
          check("beat_is_write", avm_write, mon_e.wr);
          check("beat_addr", avm_address, mon_e.addr);
          check("beat_burst", avm_burstcount, mon_e.bc);
          if (mon_e.wr) check("beat_wdata", avm_writedata, mon_e.data);
        end
      end
      if (rd_readdatavalid) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_rdata", rd_readdatavalid, 0);
        end else begin
          mon_d = exp_rd.pop_front();
          check("rdata", rd_readdata, mon_d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset with both channels requesting: nothing may be issued.
    reset_n = 1'b0;
    drive(1, 1, 'h100, 1, 1, 'h200, 'hD0, 0, 0, 0);
    tick(); tick();
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_write", avm_write, 0);
    check("rst_rd_wait", rd_waitrequest, 1);
    check("rst_wr_wait", wr_waitrequest, 1);
    check("rst_pending", dut.rd_pending_q, 0);
    check("rst_beats_left", dut.wr_beats_left_q, 0);
    check("rst_state", dut.state_q, 0);

    // Contention from reset: R, W, R, W.
    reset_n = 1'b1;
    exp_r('h100, 1); exp_w('h200, 1, 'hD0); exp_r('h100, 1); exp_w('h200, 1, 'hD0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 'h100, 1, 1, 'h200, 'hD0, 0, 0, 0);
      check("alt_rd_wait", rd_waitrequest, (i % 2 == 0) ? 1'b0 : 1'b1);
      check("alt_wr_wait", wr_waitrequest, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
    end
    drain(2, 'h11);

    // Write burst 4 with a read held: R, W x4, then R.
    exp_r('h300, 1);
    for (int k = 0; k < 4; k++) exp_w('h400, 4, 'hA0 + DW'(k));
    exp_r('h300, 1);
    drive(1, 1, 'h300, 1, 4, 'h400, 'hA0, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 'h300, 1, 4, 'h400, 'hA0 + DW'(k), 0, 0, 0);
      check("burst_rd_blocked", rd_waitrequest, 1);
      check("burst_avm_read", avm_read, 0);
      tick();
    end
    drive(1, 1, 'h300, 0, 0, 0, 0, 0, 0, 0);
    check("after_burst_rd_grant", rd_waitrequest, 0);
    tick();
    drain(2, 'h33);

    // Write burst 8, stalled 3 cycles on beat 2.
    for (int k = 0; k < 8; k++) exp_w('h500, 8, 'hC0 + DW'(k));
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 1, 8, 'h500, 'hC0 + DW'(k), 0, 0, 0);
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      drive(0, 0, 0, 1, 8, 'h500, 'hC2, 1, 0, 0);
      check("stall_avm_write", avm_write, 1);
      check("stall_addr", avm_address, 'h500);
      check("stall_wdata", avm_writedata, 'hC2);
      check("stall_wr_wait", wr_waitrequest, 1);
      check("stall_beats_left", dut.wr_beats_left_q, 6);
      tick();
    end
    for (int k = 2; k < 8; k++) begin
      drive(0, 0, 0, 1, 8, 'h500, 'hC0 + DW'(k), 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("burst8_state_idle", dut.state_q, 0);
    check("burst8_beats_left", dut.wr_beats_left_q, 0);
    tick();

    // Pending limit: the second burst-8 read waits until the count reaches zero.
    exp_r('h600, 8); exp_r('h700, 8);
    drive(1, 8, 'h600, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int s = 0; s < 2; s++) begin
      drive(1, 8, 'h700, 0, 0, 0, 0, 0, 0, 0);
      check("lim_blocked_full", rd_waitrequest, 1);
      tick();
    end
    drive(1, 8, 'h700, 0, 0, 0, 0, 0, 1, 'h50);
    check("lim_pending8", dut.rd_pending_q, 8);
    check("lim_blocked_ret", rd_waitrequest, 1);
    tick();
    drive(1, 8, 'h700, 0, 0, 0, 0, 0, 0, 0);
    check("lim_pending7", dut.rd_pending_q, 7);
    check("lim_blocked_7", rd_waitrequest, 1);
    tick();
    for (int k = 1; k < 8; k++) begin
      drive(1, 8, 'h700, 0, 0, 0, 0, 0, 1, 'h50 + DW'(k));
      check("lim_blocked_drain", rd_waitrequest, 1);
      tick();
    end
    drive(1, 8, 'h700, 0, 0, 0, 0, 0, 0, 0);
    check("lim_pending0", dut.rd_pending_q, 0);
    check("lim_granted", rd_waitrequest, 0);
    tick();
    drain(8, 'h70);

    // Same-cycle accept of burst 4 and a return with 3 pending gives 6.
    exp_r('h800, 3); exp_r('h900, 4);
    drive(1, 3, 'h800, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 4, 'h900, 0, 0, 0, 0, 0, 1, 'h60);
    check("same_cyc_grant", rd_waitrequest, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("same_cyc_pending6", dut.rd_pending_q, 6);
    drain(6, 'h80);

    // Reset mid write burst: the remaining beats are dropped and the read wins first.
    exp_r('hA00, 2); exp_w('hB00, 4, 'hF0); exp_w('hB00, 4, 'hF1); exp_r('hA00, 2);
    drive(1, 2, 'hA00, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 2, 'hA00, 1, 4, 'hB00, 'hF0, 0, 0, 0);
    tick();
    drive(1, 2, 'hA00, 1, 4, 'hB00, 'hF1, 0, 0, 0);
    tick();
    reset_n = 1'b0;
    drive(1, 2, 'hA00, 1, 4, 'hB00, 'hF2, 0, 0, 0);
    check("midrst_rd_wait", rd_waitrequest, 1);
    check("midrst_wr_wait", wr_waitrequest, 1);
    check("midrst_avm_write", avm_write, 0);
    tick();
    check("midrst_pending", dut.rd_pending_q, 0);
    check("midrst_state", dut.state_q, 0);
    reset_n = 1'b1;
    drive(1, 2, 'hA00, 1, 4, 'hB00, 'hF2, 0, 0, 0);
    check("postrst_rd_grant", rd_waitrequest, 0);
    check("postrst_wr_wait", wr_waitrequest, 1);
    tick();
    drain(2, 'h90);

    tick(); tick();
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
